// File: rtl/control.sv
// Hazard/redirect controller for the dual-issue pipeline: redirect selection, flush/stall generation, forwarding selects.
// Optional EARLY_JAL_EN: when defined, a decode-stage JAL redirects fetch early; otherwise jal_schedule/jal_addr are ignored.
module control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_full,
    input  logic        buffer_full,
    input  logic        jal_schedule,
    input  logic [31:0] jal_addr,
    input  logic        instr1_jump,
    input  logic        instr1_jump_accept,
    input  logic [31:0] instr1_jump_addr,
    input  logic        instr2_jump,
    input  logic        instr2_jump_accept,
    input  logic [31:0] instr2_jump_addr,
    input  logic [4:0]  instr1_rs1_decode,
    input  logic [4:0]  instr1_rs2_decode,
    input  logic [4:0]  instr2_rs1_decode,
    input  logic [4:0]  rd1_execute,
    input  logic [4:0]  rd2_execute,
    input  logic [4:0]  rd1_wb,
    input  logic [4:0]  rd2_wb,
    input  logic [2:0]  au_mul_lsu1,
    input  logic [2:0]  au_mul_lsu2,
    input  logic        lsu_work,
    input  logic        lsu_done,
    output logic        stop_fetch,
    output logic        jump,
    output logic [31:0] jump_addr,
    output logic        fifo_rst,
    output logic        buffer_rst,
    output logic        fifo_stall,
    output logic        buffer_stall,
    output logic        transfer_decode1_rst,
    output logic        transfer_decode2_rst,
    output logic        transfer_execute_rst,
    output logic [2:0]  hazard_select1,
    output logic [2:0]  hazard_select2
);

    logic t1, t2, jal_v, redirect;
    logic lsu_busy_q, lsu_busy_d;
    logic flush_hold_q, flush_hold_d;
    logic [4:0] rs_src [2];
    logic [2:0] sel [2];
    logic [1:0] load_use;
    logic rs2_hazard, stall;

`ifdef EARLY_JAL_EN
    assign jal_v = jal_schedule;
    logic unused_lane;
    assign unused_lane = ^{au_mul_lsu1[1:0], au_mul_lsu2[1:0]};
`else
    assign jal_v = 1'b0;
    logic unused_lane;
    assign unused_lane = ^{au_mul_lsu1[1:0], au_mul_lsu2[1:0], jal_schedule, jal_addr};
`endif

    assign t1       = instr1_jump & instr1_jump_accept;
    assign t2       = instr2_jump & instr2_jump_accept;
    assign redirect = t1 | t2 | jal_v;

    assign rs_src[0] = instr1_rs1_decode;
    assign rs_src[1] = instr2_rs1_decode;

    // Younger execute result wins over older, execute over writeback.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        always_comb begin
            sel[gi] = 3'd0;
            if (rs_src[gi] == 5'd0)              sel[gi] = 3'd0;
            else if (rs_src[gi] == rd2_execute)  sel[gi] = 3'd2;
            else if (rs_src[gi] == rd1_execute)  sel[gi] = 3'd1;
            else if (rs_src[gi] == rd2_wb)       sel[gi] = 3'd4;
            else if (rs_src[gi] == rd1_wb)       sel[gi] = 3'd3;
        end
        assign load_use[gi] = ((sel[gi] == 3'd1) & au_mul_lsu1[2]) |
                              ((sel[gi] == 3'd2) & au_mul_lsu2[2]);
    end

    assign rs2_hazard = (instr1_rs2_decode != 5'd0) &&
                        ((instr1_rs2_decode == rd1_execute) || (instr1_rs2_decode == rd2_execute));
    assign stall = (|load_use) | rs2_hazard | lsu_busy_q;

    assign flush_hold_d = redirect;
    assign lsu_busy_d   = lsu_done ? 1'b0 : (lsu_work ? 1'b1 : lsu_busy_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_busy_q   <= 1'b0;
            flush_hold_q <= 1'b0;
        end else begin
            lsu_busy_q   <= lsu_busy_d;
            flush_hold_q <= flush_hold_d;
        end
    end

    always_comb begin
        stop_fetch           = 1'b0;
        jump                 = 1'b0;
        jump_addr            = 32'd0;
        fifo_rst             = 1'b0;
        buffer_rst           = 1'b0;
        fifo_stall           = 1'b0;
        buffer_stall         = 1'b0;
        transfer_decode1_rst = 1'b0;
        transfer_decode2_rst = 1'b0;
        transfer_execute_rst = 1'b0;
        hazard_select1       = 3'd0;
        hazard_select2       = 3'd0;
        if (!rst_n) begin
            stop_fetch           = 1'b1;
            fifo_rst             = 1'b1;
            buffer_rst           = 1'b1;
            transfer_decode1_rst = 1'b1;
            transfer_decode2_rst = 1'b1;
            transfer_execute_rst = 1'b1;
        end else begin
            jump       = redirect;
            fifo_rst   = redirect | flush_hold_q;
            buffer_rst = redirect | flush_hold_q;
            if (t1) begin
                jump_addr            = instr1_jump_addr;
                transfer_decode1_rst = 1'b1;
                transfer_decode2_rst = 1'b1;
                transfer_execute_rst = 1'b1;
            end else if (t2) begin
                jump_addr            = instr2_jump_addr;
                transfer_decode1_rst = 1'b1;
                transfer_decode2_rst = 1'b1;
            end else if (jal_v) begin
`ifdef EARLY_JAL_EN
                jump_addr            = jal_addr;
`endif
                transfer_decode2_rst = 1'b1;
            end
            // A redirect discards the stalled instructions, so stall is moot.
            if (stall && !redirect) begin
                fifo_stall           = 1'b1;
                buffer_stall         = 1'b1;
                stop_fetch           = 1'b1;
                transfer_execute_rst = 1'b1;
            end
            if (fifo_full || buffer_full) stop_fetch = 1'b1;
            hazard_select1 = sel[0];
            hazard_select2 = sel[1];
        end
    end

endmodule

// File: tb/tb_control.sv
// Directed-vector bench for control: reset, redirect priority, JAL, forwarding, load-use and LSU-busy stalls.
module tb_control;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_full, buffer_full, jal_schedule;
    logic [31:0] jal_addr;
    logic        instr1_jump, instr1_jump_accept, instr2_jump, instr2_jump_accept;
    logic [31:0] instr1_jump_addr, instr2_jump_addr;
    logic [4:0]  instr1_rs1_decode, instr1_rs2_decode, instr2_rs1_decode;
    logic [4:0]  rd1_execute, rd2_execute, rd1_wb, rd2_wb;
    logic [2:0]  au_mul_lsu1, au_mul_lsu2;
    logic        lsu_work, lsu_done;
    logic        stop_fetch, jump, fifo_rst, buffer_rst, fifo_stall, buffer_stall;
    logic        transfer_decode1_rst, transfer_decode2_rst, transfer_execute_rst;
    logic [31:0] jump_addr;
    logic [2:0]  hazard_select1, hazard_select2;

    int vectors = 0;
    int miscompares = 0;

    // {fifo_rst, buffer_rst, decode1_rst, decode2_rst, execute_rst}
    logic [4:0] flushes;
    // {fifo_stall, buffer_stall, stop_fetch}
    logic [2:0] stalls;
    assign flushes = {fifo_rst, buffer_rst, transfer_decode1_rst, transfer_decode2_rst, transfer_execute_rst};
    assign stalls  = {fifo_stall, buffer_stall, stop_fetch};

    always #5 clk = ~clk;

    control dut (
        .clk(clk), .rst_n(rst_n), .fifo_full(fifo_full), .buffer_full(buffer_full),
        .jal_schedule(jal_schedule), .jal_addr(jal_addr),
        .instr1_jump(instr1_jump), .instr1_jump_accept(instr1_jump_accept), .instr1_jump_addr(instr1_jump_addr),
        .instr2_jump(instr2_jump), .instr2_jump_accept(instr2_jump_accept), .instr2_jump_addr(instr2_jump_addr),
        .instr1_rs1_decode(instr1_rs1_decode), .instr1_rs2_decode(instr1_rs2_decode),
        .instr2_rs1_decode(instr2_rs1_decode),
        .rd1_execute(rd1_execute), .rd2_execute(rd2_execute), .rd1_wb(rd1_wb), .rd2_wb(rd2_wb),
        .au_mul_lsu1(au_mul_lsu1), .au_mul_lsu2(au_mul_lsu2), .lsu_work(lsu_work), .lsu_done(lsu_done),
        .stop_fetch(stop_fetch), .jump(jump), .jump_addr(jump_addr),
        .fifo_rst(fifo_rst), .buffer_rst(buffer_rst), .fifo_stall(fifo_stall), .buffer_stall(buffer_stall),
        .transfer_decode1_rst(transfer_decode1_rst), .transfer_decode2_rst(transfer_decode2_rst),
        .transfer_execute_rst(transfer_execute_rst),
        .hazard_select1(hazard_select1), .hazard_select2(hazard_select2)
    );

    task automatic idle();
        fifo_full = 0; buffer_full = 0; jal_schedule = 0; jal_addr = 0;
        instr1_jump = 0; instr1_jump_accept = 0; instr1_jump_addr = 0;
        instr2_jump = 0; instr2_jump_accept = 0; instr2_jump_addr = 0;
        instr1_rs1_decode = 0; instr1_rs2_decode = 0; instr2_rs1_decode = 0;
        rd1_execute = 0; rd2_execute = 0; rd1_wb = 0; rd2_wb = 0;
        au_mul_lsu1 = 3'b001; au_mul_lsu2 = 3'b001; lsu_work = 0; lsu_done = 0;
    endtask

    // Outputs are sampled 1 time unit after inputs change, just past the negedge.
    task automatic test_reset();
        idle();
        rst_n = 1;
        repeat (2) @(negedge clk);
        instr1_jump = 1; instr1_jump_accept = 1; instr1_jump_addr = 32'h80;
        #1 rst_n = 0;
        #1;
        vectors++;
        if (flushes !== 5'b11111 || stop_fetch !== 1'b1 || jump !== 1'b0 || jump_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async: flushes=%b stop=%b jump=%b addr=%h, want 11111 1 0 0", flushes, stop_fetch, jump, jump_addr);
        end
        idle();
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); @(negedge clk); #1;
        vectors++;
        if (flushes !== 5'b0 || stalls !== 3'b0 || jump !== 1'b0 || hazard_select1 !== 3'd0 || hazard_select2 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release: flushes=%b stalls=%b jump=%b sel=%0d/%0d, want all 0", flushes, stalls, jump, hazard_select1, hazard_select2);
        end
    endtask

    task automatic test_redirect();
        @(negedge clk); idle();
        instr1_jump = 1; instr1_jump_accept = 1; instr1_jump_addr = 32'h100;
        instr2_jump = 1; instr2_jump_accept = 1; instr2_jump_addr = 32'h200;
        #1;
        vectors++;
        if (jump !== 1'b1 || jump_addr !== 32'h100 || flushes !== 5'b11111) begin
            miscompares++;
            $display("FAIL t1_t2: jump=%b addr=%h flushes=%b, want 1 00000100 11111", jump, jump_addr, flushes);
        end
        @(negedge clk); idle(); #1;
        vectors++;
        if (jump !== 1'b0 || flushes !== 5'b11000 || stalls !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_hold: jump=%b flushes=%b stalls=%b, want 0 11000 000", jump, flushes, stalls);
        end
        @(negedge clk); #1;
        vectors++;
        if (flushes !== 5'b0) begin
            miscompares++;
            $display("FAIL flush_hold_clear: flushes=%b, want 00000", flushes);
        end
        @(negedge clk);
        instr2_jump = 1; instr2_jump_accept = 1; instr2_jump_addr = 32'h200;
        instr1_jump = 1; instr1_jump_addr = 32'h100;
        #1;
        vectors++;
        if (jump !== 1'b1 || jump_addr !== 32'h200 || flushes !== 5'b11110) begin
            miscompares++;
            $display("FAIL t2_only: jump=%b addr=%h flushes=%b, want 1 00000200 11110", jump, jump_addr, flushes);
        end
        @(negedge clk); idle();
        instr1_jump = 1; instr1_jump_addr = 32'h300;
        #1;
        vectors++;
        if (jump !== 1'b0 || jump_addr !== 32'd0 || flushes !== 5'b11000) begin
            miscompares++;
            $display("FAIL not_taken: jump=%b addr=%h flushes=%b, want 0 00000000 11000", jump, jump_addr, flushes);
        end
        @(negedge clk); idle();
    endtask

    task automatic test_jal();
        logic        exp_jump;
        logic [31:0] exp_addr;
        logic [4:0]  exp_fl;
`ifdef EARLY_JAL_EN
        exp_jump = 1; exp_addr = 32'h40; exp_fl = 5'b11010;
`else
        exp_jump = 0; exp_addr = 32'h0; exp_fl = 5'b00000;
`endif
        @(negedge clk); idle();
        jal_schedule = 1; jal_addr = 32'h40;
        #1;
        vectors++;
        if (jump !== exp_jump || jump_addr !== exp_addr || flushes !== exp_fl) begin
            miscompares++;
            $display("FAIL jal: jump=%b addr=%h flushes=%b, want %b %h %b", jump, jump_addr, flushes, exp_jump, exp_addr, exp_fl);
        end
        @(negedge clk); idle();
        @(negedge clk);
    endtask

    task automatic test_forward();
        logic [4:0] rs   [5] = '{5'd5, 5'd0, 5'd9, 5'd9, 5'd5};
        logic [4:0] r1e  [5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd5};
        logic [4:0] r2e  [5] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0] r1w  [5] = '{5'd5, 5'd0, 5'd9, 5'd9, 5'd0};
        logic [4:0] r2w  [5] = '{5'd0, 5'd0, 5'd9, 5'd0, 5'd5};
        logic [2:0] want [5] = '{3'd2, 3'd0, 3'd4, 3'd3, 3'd1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle();
            instr1_rs1_decode = rs[i]; instr2_rs1_decode = rs[i];
            rd1_execute = r1e[i]; rd2_execute = r2e[i]; rd1_wb = r1w[i]; rd2_wb = r2w[i];
            #1;
            vectors++;
            if (hazard_select1 !== want[i] || hazard_select2 !== want[i] || stalls !== 3'b000) begin
                miscompares++;
                $display("FAIL forward[%0d]: sel1=%0d sel2=%0d stalls=%b, want %0d %0d 000", i, hazard_select1, hazard_select2, stalls, want[i], want[i]);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk); idle();
        instr2_rs1_decode = 7; rd1_execute = 7; au_mul_lsu1 = 3'b100;
        #1;
        vectors++;
        if (stalls !== 3'b111 || flushes !== 5'b00001 || hazard_select2 !== 3'd1) begin
            miscompares++;
            $display("FAIL load_use: stalls=%b flushes=%b sel2=%0d, want 111 00001 1", stalls, flushes, hazard_select2);
        end
        @(negedge clk); idle();
        instr1_rs2_decode = 3; rd2_execute = 3;
        #1;
        vectors++;
        if (stalls !== 3'b111 || flushes !== 5'b00001) begin
            miscompares++;
            $display("FAIL rs2_exec: stalls=%b flushes=%b, want 111 00001", stalls, flushes);
        end
        @(negedge clk); idle();
        instr1_rs2_decode = 3; rd1_wb = 3;
        #1;
        vectors++;
        if (stalls !== 3'b000 || flushes !== 5'b00000) begin
            miscompares++;
            $display("FAIL rs2_wb: stalls=%b flushes=%b, want 000 00000", stalls, flushes);
        end
        @(negedge clk); idle();
        fifo_full = 1;
        #1;
        vectors++;
        if (stalls !== 3'b001 || flushes !== 5'b00000) begin
            miscompares++;
            $display("FAIL fifo_full: stalls=%b flushes=%b, want 001 00000", stalls, flushes);
        end
    endtask

    task automatic test_lsu_busy();
        @(negedge clk); idle();
        lsu_work = 1;
        #1;
        vectors++;
        if (stalls !== 3'b000) begin
            miscompares++;
            $display("FAIL lsu_c0: stalls=%b, want 000", stalls);
        end
        @(negedge clk); lsu_work = 0; #1;
        vectors++;
        if (stalls !== 3'b111 || flushes !== 5'b00001) begin
            miscompares++;
            $display("FAIL lsu_c1: stalls=%b flushes=%b, want 111 00001", stalls, flushes);
        end
        @(negedge clk);
        instr1_jump = 1; instr1_jump_accept = 1; instr1_jump_addr = 32'h500;
        #1;
        vectors++;
        if (jump !== 1'b1 || jump_addr !== 32'h500 || stalls !== 3'b000 || flushes !== 5'b11111) begin
            miscompares++;
            $display("FAIL lsu_c2_t1: jump=%b addr=%h stalls=%b flushes=%b, want 1 00000500 000 11111", jump, jump_addr, stalls, flushes);
        end
        @(negedge clk); idle(); lsu_done = 1; #1;
        vectors++;
        if (stalls !== 3'b111 || flushes !== 5'b11001) begin
            miscompares++;
            $display("FAIL lsu_c3_done: stalls=%b flushes=%b, want 111 11001", stalls, flushes);
        end
        @(negedge clk); lsu_done = 0; #1;
        vectors++;
        if (stalls !== 3'b000 || flushes !== 5'b00000) begin
            miscompares++;
            $display("FAIL lsu_c4: stalls=%b flushes=%b, want 000 00000", stalls, flushes);
        end
        @(negedge clk); lsu_work = 1; lsu_done = 1;
        @(negedge clk); lsu_work = 0; lsu_done = 0; #1;
        vectors++;
        if (stalls !== 3'b000) begin
            miscompares++;
            $display("FAIL lsu_done_wins: stalls=%b, want 000", stalls);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_redirect();
        test_jal();
        test_forward();
        test_stall();
        test_lsu_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/control.md
Name: control

Overview:
- Central hazard/redirect controller for the dual-issue RISC-V pipeline.
- Selects the fetch redirect target (early JAL from decode, or a taken jump in execute slot 1 or slot 2).
- Generates flush/stall controls for the fetch FIFO, the issue buffer and the decode/execute transfer registers.
- Computes operand-forwarding selects from the execute and writeback stages.

Parameters:
- None. Widths are fixed: XLEN = 32, register index = 5 bits.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fifo_full  in  1  fetch FIFO full
buffer_full  in  1  issue buffer full
jal_schedule  in  1  decode detected a JAL
jal_addr  in  32  JAL target
instr1_jump  in  1  execute slot1 is a jump/branch
instr1_jump_accept  in  1  slot1 branch taken
instr1_jump_addr  in  32  slot1 target
instr2_jump  in  1  execute slot2 is a jump/branch
instr2_jump_accept  in  1  slot2 branch taken
instr2_jump_addr  in  32  slot2 target
instr1_rs1_decode  in  5  decode slot1 rs1
instr1_rs2_decode  in  5  decode slot1 rs2
instr2_rs1_decode  in  5  decode slot2 rs1
rd1_execute, rd2_execute  in  5  execute-stage destinations
rd1_wb, rd2_wb  in  5  writeback-stage destinations
au_mul_lsu1, au_mul_lsu2  in  3  execute unit one-hot: [0]=AU, [1]=MUL, [2]=LSU
lsu_work  in  1  LSU accepted a multi-cycle access
lsu_done  in  1  LSU access complete
stop_fetch  out  1  halt PC/fetch
jump  out  1  redirect PC
jump_addr  out  32  redirect target
fifo_rst, buffer_rst  out  1  flush fetch FIFO / issue buffer
fifo_stall, buffer_stall  out  1  hold FIFO / buffer
transfer_decode1_rst, transfer_decode2_rst, transfer_execute_rst  out  1  bubble into decode slot1 / slot2 / execute register
hazard_select1, hazard_select2  out  3  forward select for instr1_rs1 / instr2_rs1

Behaviour:
- Reset (rst_n low, asynchronous):
  - fifo_rst, buffer_rst, all transfer_*_rst and stop_fetch = 1.
  - jump = 0, jump_addr = 0, stalls = 0, selects = 0.
  - Internal lsu_busy = 0, flush_hold = 0.
- Redirect priority (combinational):
  1. t1 = instr1_jump & instr1_jump_accept.
  2. t2 = instr2_jump & instr2_jump_accept.
  3. jal_schedule.
  - jump = OR of the above; jump_addr = winner's address, else 0.
  - Simultaneous t1 and t2: t1 wins (older instruction).
- Flush on t1:
  - fifo_rst, buffer_rst, transfer_decode1_rst, transfer_decode2_rst, transfer_execute_rst = 1. The execute flush kills the younger slot2 result.
- Flush on t2 (no t1):
  - Same, except transfer_execute_rst = 0.
- Flush on jal only:
  - fifo_rst, buffer_rst, transfer_decode2_rst = 1.
- flush_hold register:
  - Set on any redirect; holds fifo_rst and buffer_rst high one extra cycle to kill in-flight fetch.
  - Cleared the following cycle unless a new redirect occurs.
- lsu_busy register:
  - Set on lsu_work.
  - Cleared on lsu_done; lsu_done wins when both are asserted.
- Forward select encoding, per source register:
  - 0 = regfile, 1 = rd1_execute, 2 = rd2_execute, 3 = rd1_wb, 4 = rd2_wb.
  - Priority order: 2, 1, 4, 3 (execute over wb; slot2 younger over slot1).
  - Source x0 always yields 0. Codes 5–7 are unused.
- instr1_rs2 has no forward path. A nonzero match against rd1_execute or rd2_execute causes a stall. A wb match needs no action (regfile write-through).
- Load-use hazard: a source matches an execute rd whose unit is LSU (au_mul_lsu bit2). This forces a stall; the select still reports the match.
- stall = load-use | rs2 execute hazard | lsu_busy.
  - On stall: fifo_stall = buffer_stall = stop_fetch = 1, and transfer_execute_rst = 1 (bubble).
  - A redirect overrides stall: flush outputs win; stall outputs are forced to 0 that cycle.
- stop_fetch additionally asserts when fifo_full | buffer_full.
- With no hazard and no redirect, all flush/stall outputs are 0.

Optional Feature:
- Macro EARLY_JAL_EN.
- Defined: jal_schedule redirects and flushes as above.
- Undefined: jal_schedule and jal_addr are ignored; JAL resolves via the execute jump inputs.

Test Plan:
- rst_n = 0 mid-run → all flush outputs and stop_fetch = 1, jump = 0 immediately (asynchronous). Release → all 0 next edge with idle inputs.
- t1 (addr 0x100) and t2 (addr 0x200) in the same cycle → jump = 1, jump_addr = 0x100, all five resets = 1. Next cycle, inputs idle → fifo_rst = buffer_rst = 1 only (flush_hold).
- jal_schedule = 1, jal_addr = 0x40 alone → jump_addr = 0x40, transfer_decode2_rst = 1, transfer_execute_rst = 0. With EARLY_JAL_EN undefined → jump = 0.
- instr1_rs1 = 5, rd2_execute = 5 (AU), rd1_wb = 5 → hazard_select1 = 2. With rs1 = 0 → hazard_select1 = 0.
- instr2_rs1 = 7, rd1_execute = 7, au_mul_lsu1 = 3'b100 → fifo_stall = buffer_stall = transfer_execute_rst = 1, hazard_select2 = 1.
- lsu_work pulse, lsu_done 3 cycles later → stall high exactly until the cycle after lsu_done. A t1 during the stall → jump = 1, stalls = 0.
